// File: rtl/acumulador_saturacion_pkg.sv
// Shared definitions for the accumulate-and-saturate output stage.
//   - Default fixed-point geometry (N, F) of the narrow signed Q(N-F).F format.
//   - Narrow range limits for the default geometry.
//   - Accumulator guard width: headroom for summing up to 16 products.
//   - FSM state encoding.
// Optional feature macro: ACUM_REDONDEO_EN (round half up before rescaling).
package acumulador_saturacion_pkg;

    localparam int unsigned N_DEF = 25;
    localparam int unsigned F_DEF = 16;

    // Four guard bits cover 16 full-scale products without wrapping.
    localparam int unsigned GUARD = 4;

    localparam longint NARROW_MAX = (64'sd1 <<< (N_DEF - 1)) - 64'sd1;
    localparam longint NARROW_MIN = -(64'sd1 <<< (N_DEF - 1));

    localparam logic [1:0] ESPERA  = 2'd0;
    localparam logic [1:0] ACUMULA = 2'd1;
    localparam logic [1:0] SATURA  = 2'd2;

endpackage

// File: rtl/saturador_q.sv
// Combinational rescale-and-clamp of a wide accumulator to signed N-bit fixed point.
// The accumulator carries 2F fractional bits; the result carries F.
//   acc      in   AW  signed accumulator value
//   valor    out  N   signed rescaled, saturated value
//   saturado out  1   valor was clipped to the N-bit range
// Optional feature macro: ACUM_REDONDEO_EN. When defined, 2^(F-1) is added before the
// shift (round half toward +inf); otherwise the shift truncates toward -inf.
module saturador_q
    import acumulador_saturacion_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned F  = F_DEF,
    parameter int unsigned AW = 2 * N + GUARD
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [N-1:0]  valor,
    output logic                 saturado
);

    // One extra bit so the rounding addend can never wrap the accumulator.
    localparam int unsigned EW = AW + 1;

    logic signed [EW-1:0] extendido;
    logic signed [EW-1:0] redondeado;
    logic signed [EW-1:0] escalado;
    logic [EW-N:0]        superiores;
    logic                 desborde_pos;
    logic                 desborde_neg;

    assign extendido = {acc[AW-1], acc};

`ifdef ACUM_REDONDEO_EN
    localparam logic signed [EW-1:0] MEDIO = EW'(1) << (F - 1);
    assign redondeado = extendido + MEDIO;
`else
    assign redondeado = extendido;
`endif

    assign escalado = redondeado >>> F;

    // The value fits in N bits only when every bit from N-1 upward equals the sign.
    assign superiores   = escalado[EW-1:N-1];
    assign desborde_pos = !escalado[EW-1] && (|superiores);
    assign desborde_neg = escalado[EW-1] && !(&superiores);

    always_comb begin
        valor    = escalado[N-1:0];
        saturado = 1'b0;
        if (desborde_pos) begin
            valor    = {1'b0, {(N - 1){1'b1}}};
            saturado = 1'b1;
        end else if (desborde_neg) begin
            valor    = {1'b1, {(N - 1){1'b0}}};
            saturado = 1'b1;
        end
    end

endmodule

// File: rtl/acumulador_saturacion.sv
// Accumulates TERMS signed 2N-bit products, rescales the sum to signed N-bit fixed
// point with saturation and emits it as a registered sample with a one-cycle strobe.
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   valores       in   2N  signed product (2F fractional bits)
//   valores_valid in   1   valores is valid this cycle
//   limpiar       in   1   synchronous abort of the current accumulation
//   listo         out  1   product accepted when valores_valid & listo
//   dato_out      out  N   signed saturated result, held until the next strobe
//   dato_valid    out  1   one-cycle strobe, dato_out is new
//   saturado      out  1   dato_out was clipped, updated with dato_valid
// Optional feature macro: ACUM_REDONDEO_EN (rounding inside saturador_q).
module acumulador_saturacion
    import acumulador_saturacion_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned F     = F_DEF,
    parameter int unsigned TERMS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [2*N-1:0] valores,
    input  logic                  valores_valid,
    input  logic                  limpiar,
    output logic                  listo,
    output logic signed [N-1:0]   dato_out,
    output logic                  dato_valid,
    output logic                  saturado
);

    localparam int unsigned AW   = 2 * N + GUARD;
    localparam logic [3:0]  ULTIMO = 4'(TERMS - 1);

    logic [1:0]           state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [3:0]           cnt_q, cnt_d;
    logic signed [N-1:0]  dato_out_q, dato_out_d;
    logic                 dato_valid_q, dato_valid_d;
    logic                 saturado_q, saturado_d;

    logic                 acepta;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] suma;
    logic signed [AW-1:0] sat_in;
    logic signed [N-1:0]  sat_valor;
    logic                 sat_flag;

    assign listo    = (state_q != SATURA);
    assign acepta   = valores_valid && listo;
    assign prod_ext = {{GUARD{valores[2*N-1]}}, valores};
    assign suma     = acc_q + prod_ext;

    // The result is clamped on the edge that accepts the last product so that the
    // outputs are registered and valid throughout the SATURA cycle.
    assign sat_in = (state_q == ESPERA) ? prod_ext : suma;

    saturador_q #(
        .N  (N),
        .F  (F),
        .AW (AW)
    ) u_saturador (
        .acc      (sat_in),
        .valor    (sat_valor),
        .saturado (sat_flag)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dato_out_d   = dato_out_q;
        dato_valid_d = 1'b0;
        saturado_d   = saturado_q;

        case (state_q)
            ESPERA: begin
                if (limpiar) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (acepta) begin
                    acc_d = prod_ext;
                    cnt_d = 4'd1;
                    if (TERMS == 1) begin
                        state_d      = SATURA;
                        cnt_d        = '0;
                        dato_out_d   = sat_valor;
                        saturado_d   = sat_flag;
                        dato_valid_d = 1'b1;
                    end else begin
                        state_d = ACUMULA;
                    end
                end
            end
            ACUMULA: begin
                if (limpiar) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ESPERA;
                end else if (acepta) begin
                    acc_d = suma;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == ULTIMO) begin
                        state_d      = SATURA;
                        cnt_d        = '0;
                        dato_out_d   = sat_valor;
                        saturado_d   = sat_flag;
                        dato_valid_d = 1'b1;
                    end
                end
            end
            SATURA: begin
                state_d = ESPERA;
            end
            default: begin
                state_d = ESPERA;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ESPERA;
            acc_q        <= '0;
            cnt_q        <= '0;
            dato_out_q   <= '0;
            dato_valid_q <= 1'b0;
            saturado_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dato_out_q   <= dato_out_d;
            dato_valid_q <= dato_valid_d;
            saturado_q   <= saturado_d;
        end
    end

    assign dato_out   = dato_out_q;
    assign dato_valid = dato_valid_q;
    assign saturado   = saturado_q;

endmodule

// File: tb/tb_acumulador_saturacion.sv
// Directed self-checking bench for acumulador_saturacion.
// Main instance uses TERMS=3; a second instance with TERMS=1 covers the rounding
// boundary, whose expected values depend on ACUM_REDONDEO_EN.
module tb_acumulador_saturacion;
    import acumulador_saturacion_pkg::*;

    localparam longint UNO = 64'sd1 <<< 32;  // 1.0 in product format

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [49:0] valores = '0;
    logic               valores_valid = 1'b0;
    logic               limpiar = 1'b0;
    logic               listo;
    logic signed [24:0] dato_out;
    logic               dato_valid;
    logic               saturado;

    logic signed [49:0] valores1 = '0;
    logic               valores_valid1 = 1'b0;
    logic               listo1;
    logic signed [24:0] dato_out1;
    logic               dato_valid1;
    logic               saturado1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    acumulador_saturacion #(.N(25), .F(16), .TERMS(3)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valores       (valores),
        .valores_valid (valores_valid),
        .limpiar       (limpiar),
        .listo         (listo),
        .dato_out      (dato_out),
        .dato_valid    (dato_valid),
        .saturado      (saturado)
    );

    acumulador_saturacion #(.N(25), .F(16), .TERMS(1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .valores       (valores1),
        .valores_valid (valores_valid1),
        .limpiar       (limpiar),
        .listo         (listo1),
        .dato_out      (dato_out1),
        .dato_valid    (dato_valid1),
        .saturado      (saturado1)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one product for one cycle; returns 1 time unit after the edge.
    task automatic send(input longint v);
        valores       = v[49:0];
        valores_valid = 1'b1;
        @(posedge clk);
        #1;
        valores_valid = 1'b0;
    endtask

    task automatic send1(input longint v);
        valores1       = v[49:0];
        valores_valid1 = 1'b1;
        @(posedge clk);
        #1;
        valores_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    longint exp_pos, exp_neg;

    initial begin
        // Reset state
        #2;
        check("rst_dato_out", dato_out, 0);
        check("rst_dato_valid", dato_valid, 0);
        check("rst_saturado", saturado, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_listo", listo, 1);

        // 1.0 + 1.0 + 0.5 = 2.5
        send(UNO);
        send(UNO);
        check("lat_no_early_valid", dato_valid, 0);
        send(UNO >>> 1);
        check("basic_valid", dato_valid, 1);
        check("basic_dato", dato_out, 163840);
        check("basic_sat", saturado, 0);
        check("basic_listo_low", listo, 0);
        idle(1);
        check("basic_valid_one_cycle", dato_valid, 0);
        check("basic_listo_back", listo, 1);
        check("basic_dato_hold", dato_out, 163840);

        // Abort after two products; concurrent product is discarded
        send(UNO * 7);
        send(UNO * 7);
        limpiar       = 1'b1;
        valores       = 50'(UNO * 7);
        valores_valid = 1'b1;
        @(posedge clk);
        #1;
        limpiar       = 1'b0;
        valores_valid = 1'b0;
        check("clr_no_valid", dato_valid, 0);
        idle(2);
        check("clr_no_valid_later", dato_valid, 0);
        check("clr_dato_hold", dato_out, 163840);
        send(UNO);
        send(UNO);
        send(UNO);
        check("clr_after_valid", dato_valid, 1);
        check("clr_after_dato", dato_out, 196608);
        idle(1);

        // Gapped input, product held high through SATURA
        send(UNO);
        idle(2);
        send(UNO);
        idle(1);
        valores       = 50'(UNO);
        valores_valid = 1'b1;
        @(posedge clk);
        #1;
        valores = 50'(UNO * 5);  // still offered during SATURA
        check("gap_valid", dato_valid, 1);
        check("gap_dato", dato_out, 196608);
        check("gap_listo_low", listo, 0);
        @(posedge clk);  // not accepted
        #1;
        check("gap_listo_esp", listo, 1);
        @(posedge clk);  // accepted in ESPERA
        #1;
        valores_valid = 1'b0;
        send(UNO);
        send(UNO);
        check("gap_held_valid", dato_valid, 1);
        check("gap_held_dato", dato_out, 458752);
        idle(1);

        // Saturation both ways
        send(UNO * 200);
        send(UNO * 200);
        send(UNO * 200);
        check("satp_valid", dato_valid, 1);
        check("satp_dato", dato_out, NARROW_MAX);
        check("satp_flag", saturado, 1);
        idle(1);
        send(-UNO * 200);
        send(-UNO * 200);
        send(-UNO * 200);
        check("satn_dato", dato_out, NARROW_MIN);
        check("satn_flag", saturado, 1);
        idle(1);

        // Reset mid-accumulation
        send(UNO);
        send(UNO);
        rst_n = 1'b0;
        #2;
        check("mrst_dato", dato_out, 0);
        check("mrst_sat", saturado, 0);
        check("mrst_valid", dato_valid, 0);
        #3 rst_n = 1'b1;
        idle(1);
        check("mrst_no_valid", dato_valid, 0);
        send(UNO);
        send(UNO);
        send(UNO);
        check("mrst_after_valid", dato_valid, 1);
        check("mrst_after_dato", dato_out, 196608);
        idle(1);

        // Half-LSB boundary with a single term
`ifdef ACUM_REDONDEO_EN
        exp_pos = 1;
        exp_neg = 0;
`else
        exp_pos = 0;
        exp_neg = -1;
`endif
        send1(64'sh8000);
        check("t1_valid", dato_valid1, 1);
        check("t1_pos_half", dato_out1, exp_pos);
        check("t1_listo_low", listo1, 0);
        idle(1);
        send1(-64'sh8000);
        check("t1_neg_half", dato_out1, exp_neg);
        check("t1_sat", saturado1, 0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
